// File: rtl/nand_logic_unit_if.sv
// Operand/result bundle for nand_logic_unit; LOGIC_OR_XOR_EN adds ab_or/ab_xor
// and widens sel to 3 bits.
interface nand_logic_unit_if #(
    parameter int unsigned WIDTH = 16
);
`ifdef LOGIC_OR_XOR_EN
    localparam int unsigned SEL_W = 3;
`else
    localparam int unsigned SEL_W = 2;
`endif

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic [WIDTH-1:0] a_not;
    logic [WIDTH-1:0] ab_nand;
    logic [WIDTH-1:0] ab_and;
    logic [WIDTH-1:0] y;
    logic             y_zero;
`ifdef LOGIC_OR_XOR_EN
    logic [WIDTH-1:0] ab_or;
    logic [WIDTH-1:0] ab_xor;
`endif

    modport master (
        output in_valid, a, b, sel,
`ifdef LOGIC_OR_XOR_EN
        input  ab_or, ab_xor,
`endif
        input  out_valid, a_not, ab_nand, ab_and, y, y_zero
    );

    modport slave (
        input  in_valid, a, b, sel,
`ifdef LOGIC_OR_XOR_EN
        output ab_or, ab_xor,
`endif
        output out_valid, a_not, ab_nand, ab_and, y, y_zero
    );
endinterface

// File: rtl/nand_logic_unit.sv
// Registered bitwise logic unit built solely from a 2-input NAND primitive.
// Optional macro LOGIC_OR_XOR_EN adds registered OR/XOR results (sel 4/5).
module nand_logic_unit_nand2 (
    input  logic i_x,
    input  logic i_y,
    output logic o_z
);
    assign o_z = ~(i_x & i_y);
endmodule

module nand_logic_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    nand_logic_unit_if.slave   bus
);
`ifdef LOGIC_OR_XOR_EN
    localparam int unsigned SEL_W = 3;
`else
    localparam int unsigned SEL_W = 2;
`endif

    logic [WIDTH-1:0] w_not_a;
    logic [WIDTH-1:0] w_nand_ab;
    logic [WIDTH-1:0] w_and_ab;
    logic [WIDTH-1:0] w_y;
    logic             w_y_zero;
`ifdef LOGIC_OR_XOR_EN
    logic [WIDTH-1:0] w_not_b;
    logic [WIDTH-1:0] w_or_ab;
    logic [WIDTH-1:0] w_xor_t;
    logic [WIDTH-1:0] w_xor_ab;
`endif

    logic             r_out_valid;
    logic [WIDTH-1:0] r_a_not;
    logic [WIDTH-1:0] r_ab_nand;
    logic [WIDTH-1:0] r_ab_and;
    logic [WIDTH-1:0] r_y;
    logic             r_y_zero;
`ifdef LOGIC_OR_XOR_EN
    logic [WIDTH-1:0] r_ab_or;
    logic [WIDTH-1:0] r_ab_xor;
`endif

    // Per-bit gate network: Not(x)=Nand(x,x), And(x,y)=Not(Nand(x,y))
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        nand_logic_unit_nand2 u_not_a   (.i_x(bus.a[i]),      .i_y(bus.a[i]),      .o_z(w_not_a[i]));
        nand_logic_unit_nand2 u_nand_ab (.i_x(bus.a[i]),      .i_y(bus.b[i]),      .o_z(w_nand_ab[i]));
        nand_logic_unit_nand2 u_and_ab  (.i_x(w_nand_ab[i]),  .i_y(w_nand_ab[i]),  .o_z(w_and_ab[i]));
`ifdef LOGIC_OR_XOR_EN
        nand_logic_unit_nand2 u_not_b   (.i_x(bus.b[i]),      .i_y(bus.b[i]),      .o_z(w_not_b[i]));
        nand_logic_unit_nand2 u_or_ab   (.i_x(w_not_a[i]),    .i_y(w_not_b[i]),    .o_z(w_or_ab[i]));
        nand_logic_unit_nand2 u_xor_t   (.i_x(w_or_ab[i]),    .i_y(w_nand_ab[i]),  .o_z(w_xor_t[i]));
        nand_logic_unit_nand2 u_xor_ab  (.i_x(w_xor_t[i]),    .i_y(w_xor_t[i]),    .o_z(w_xor_ab[i]));
`endif
    end

    // Result select; unused codes yield zero
    always_comb begin
        w_y = '0;
        case (bus.sel)
            SEL_W'(0): w_y = w_not_a;
            SEL_W'(1): w_y = w_nand_ab;
            SEL_W'(2): w_y = w_and_ab;
            SEL_W'(3): w_y = bus.a;
`ifdef LOGIC_OR_XOR_EN
            SEL_W'(4): w_y = w_or_ab;
            SEL_W'(5): w_y = w_xor_ab;
`endif
            default:   w_y = '0;
        endcase
    end

    assign w_y_zero = (w_y == '0);

    // Results load only on a valid sample so idle/X operands cannot disturb them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_a_not     <= '0;
            r_ab_nand   <= '0;
            r_ab_and    <= '0;
            r_y         <= '0;
            r_y_zero    <= 1'b0;
`ifdef LOGIC_OR_XOR_EN
            r_ab_or     <= '0;
            r_ab_xor    <= '0;
`endif
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_a_not   <= w_not_a;
                r_ab_nand <= w_nand_ab;
                r_ab_and  <= w_and_ab;
                r_y       <= w_y;
                r_y_zero  <= w_y_zero;
`ifdef LOGIC_OR_XOR_EN
                r_ab_or   <= w_or_ab;
                r_ab_xor  <= w_xor_ab;
`endif
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.a_not     = r_a_not;
    assign bus.ab_nand   = r_ab_nand;
    assign bus.ab_and    = r_ab_and;
    assign bus.y         = r_y;
    assign bus.y_zero    = r_y_zero;
`ifdef LOGIC_OR_XOR_EN
    assign bus.ab_or     = r_ab_or;
    assign bus.ab_xor    = r_ab_xor;
`endif
endmodule

// File: tb/tb_nand_logic_unit.sv
// Scoreboard bench for nand_logic_unit: a 16-bit and a 1-bit instance share clk/rst.
`timescale 1ns/1ps
module tb_nand_logic_unit;
`ifdef LOGIC_OR_XOR_EN
    localparam int unsigned SEL_W = 3;
`else
    localparam int unsigned SEL_W = 2;
`endif

    typedef struct packed {
        logic [15:0] a_not;
        logic [15:0] ab_nand;
        logic [15:0] ab_and;
        logic [15:0] y;
        logic        y_zero;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t q16[$];
    exp_t q1[$];

    nand_logic_unit_if #(.WIDTH(16)) b16 ();
    nand_logic_unit_if #(.WIDTH(1))  b1 ();

    nand_logic_unit #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
    nand_logic_unit #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input int s);
        b16.in_valid = v;
        b16.a        = a;
        b16.b        = b;
        b16.sel      = SEL_W'(s);
    endtask

    task automatic push16(input logic [15:0] n, input logic [15:0] nd, input logic [15:0] an,
                          input logic [15:0] y, input logic z);
        exp_t e;
        e.a_not = n; e.ab_nand = nd; e.ab_and = an; e.y = y; e.y_zero = z;
        q16.push_back(e);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ov"},   64'(b16.out_valid), 64'd0);
        chk({tag, "_not"},  64'(b16.a_not),     64'd0);
        chk({tag, "_nand"}, 64'(b16.ab_nand),   64'd0);
        chk({tag, "_and"},  64'(b16.ab_and),    64'd0);
        chk({tag, "_y"},    64'(b16.y),         64'd0);
        chk({tag, "_yz"},   64'(b16.y_zero),    64'd0);
    endtask

    // Monitor: pops expected results whenever a DUT presents out_valid
    always @(negedge clk) begin
        exp_t e;
        if (b16.out_valid === 1'b1) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL unexp_valid16: got out_valid=1 want no result");
            end else begin
                e = q16.pop_front();
                chk("sb16_not",  64'(b16.a_not),   64'(e.a_not));
                chk("sb16_nand", 64'(b16.ab_nand), 64'(e.ab_nand));
                chk("sb16_and",  64'(b16.ab_and),  64'(e.ab_and));
                chk("sb16_y",    64'(b16.y),       64'(e.y));
                chk("sb16_yz",   64'(b16.y_zero),  64'(e.y_zero));
            end
        end
        if (b1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL unexp_valid1: got out_valid=1 want no result");
            end else begin
                e = q1.pop_front();
                chk("sb1_not",  64'(b1.a_not),   64'(e.a_not[0]));
                chk("sb1_nand", 64'(b1.ab_nand), 64'(e.ab_nand[0]));
                chk("sb1_and",  64'(b1.ab_and),  64'(e.ab_and[0]));
                chk("sb1_y",    64'(b1.y),       64'(e.y[0]));
                chk("sb1_yz",   64'(b1.y_zero),  64'(e.y_zero));
            end
        end
    end

    initial begin
        logic [15:0] wop_y [4];
        logic [1:0]  tv_ab [4];
        logic [2:0]  tv_exp [4];
        exp_t        e;

        wop_y  = '{16'hFF00, 16'hFFF0, 16'h000F, 16'h00FF};
        tv_ab  = '{2'b00, 2'b01, 2'b10, 2'b11};
        // {not, nand, and} per (a,b)
        tv_exp = '{3'b110, 3'b110, 3'b010, 3'b001};
        total = 0;
        bad   = 0;

        // Reset dominates in_valid for two edges
        rst = 1'b1;
        drive16(1'b1, 16'hFFFF, 16'hFFFF, 3);
        b1.in_valid = 1'b1; b1.a = 1'b1; b1.b = 1'b1; b1.sel = '0;
        tick();
        chk_cleared("rst1");
        chk("rst1_ov1", 64'(b1.out_valid), 64'd0);
        tick();
        chk_cleared("rst2");
        chk("rst2_ov1", 64'(b1.out_valid), 64'd0);

        // Truth sweep on the 1-bit instance
        rst = 1'b0;
        b16.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b1.in_valid = 1'b1;
            b1.a = tv_ab[k][1];
            b1.b = tv_ab[k][0];
            e = '0;
            e.a_not   = 16'(tv_exp[k][2]);
            e.ab_nand = 16'(tv_exp[k][1]);
            e.ab_and  = 16'(tv_exp[k][0]);
            e.y       = 16'(tv_exp[k][2]);
            e.y_zero  = ~tv_exp[k][2];
            q1.push_back(e);
            tick();
            chk("truth_ov", 64'(b1.out_valid), 64'd1);
        end
        b1.in_valid = 1'b0;

        // Word ops with sel cycled
        for (int s = 0; s < 4; s++) begin
            drive16(1'b1, 16'h00FF, 16'h0F0F, s);
            push16(16'hFF00, 16'hFFF0, 16'h000F, wop_y[s], 1'b0);
            tick();
            chk("wop_ov", 64'(b16.out_valid), 64'd1);
        end

        // Capture then hold with changing/unknown operands
        drive16(1'b1, 16'h1234, 16'hFFFF, 2);
        push16(16'hEDCB, 16'hEDCB, 16'h1234, 16'h1234, 1'b0);
        tick();
        chk("hold_cap_ov", 64'(b16.out_valid), 64'd1);
        drive16(1'b0, 16'h0000, 16'hFFFF, 2);
        tick();
        chk("hold1_ov", 64'(b16.out_valid), 64'd0);
        chk("hold1_y",  64'(b16.y),         64'h1234);
        b16.a = 16'hxxxx;
        b16.b = 16'hzzzz;
        tick();
        chk("hold2_ov",  64'(b16.out_valid), 64'd0);
        chk("hold2_y",   64'(b16.y),         64'h1234);
        chk("hold2_and", 64'(b16.ab_and),    64'h1234);
        chk("hold2_not", 64'(b16.a_not),     64'hEDCB);

        // Zero flag follows the new y
        drive16(1'b1, 16'hAAAA, 16'h5555, 2);
        push16(16'h5555, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        tick();
        drive16(1'b1, 16'hAAAA, 16'h5555, 1);
        push16(16'h5555, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        tick();

        // Mid-stream reset between two valid samples
        drive16(1'b1, 16'h00FF, 16'h0F0F, 3);
        push16(16'hFF00, 16'hFFF0, 16'h000F, 16'h00FF, 1'b0);
        tick();
        rst = 1'b1;
        drive16(1'b1, 16'hFFFF, 16'hFFFF, 3);
        tick();
        chk_cleared("midrst");
        rst = 1'b0;
        drive16(1'b1, 16'h0F0F, 16'h00FF, 0);
        push16(16'hF0F0, 16'hFFF0, 16'h000F, 16'hF0F0, 1'b0);
        tick();
        chk("post_rst_ov", 64'(b16.out_valid), 64'd1);
        drive16(1'b0, 16'h0000, 16'h0000, 0);
        tick();
        chk("post_rst_idle_ov", 64'(b16.out_valid), 64'd0);

        tick();
        tick();
        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q1_drained",  64'(q1.size()),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
